// File: rtl/hack_cpu_ctrl_pkg.sv
// Shared types and instruction field positions for the Hack
// control/datapath sequencer.
package cpu_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 15;

    localparam int TYPE    = 15;
    localparam int ABIT    = 12;
    localparam int CTRL_HI = 11;
    localparam int CTRL_LO = 6;
    localparam int DEST_D1 = 5;
    localparam int DEST_D2 = 4;
    localparam int DEST_D3 = 3;
    localparam int JMP_HI  = 2;
    localparam int JMP_LO  = 0;
    localparam int JMP_W   = JMP_HI - JMP_LO + 1;
    localparam int CTRL_W  = CTRL_HI - CTRL_LO + 1;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        MREAD,
        EXEC,
        MWRITE
    } state_t;

endpackage

// File: rtl/hack_cpu_ctrl_if.sv
// Instruction- and data-memory request/ack bundle of the sequencer.
// master = CPU side, slave = memory side.
interface hack_cpu_ctrl_if
    import cpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] instr;

    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, instr,
        output dmem_req, dmem_we,
        output dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, instr,
        input  dmem_req, dmem_we,
        input  dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );

endinterface

// File: rtl/hack_cpu_ctrl_jump_cond.sv
// Jump resolution from the jjj field and the ALU flags.
module jump_cond
    import cpu_pkg::*;
(
    input  logic [JMP_W-1:0] jjj,
    input  logic             zr,
    input  logic             ng,
    output logic             taken
);

    logic pos;

    assign pos   = ~ng & ~zr;
    assign taken = (jjj[2] & ng)
                 | (jjj[1] & zr)
                 | (jjj[0] & pos);

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack sequencer: PC/A/D state, fetch, decode, M access
// and jump resolution; the ALU is an external combinational sibling.
module hack_cpu_ctrl
    import cpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
)
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_ack,
    input  logic [DATA_W-1:0] i_instr,
    output logic              o_dmem_req,
    output logic              o_dmem_we,
    output logic [ADDR_W-1:0] o_dmem_addr,
    output logic [DATA_W-1:0] o_dmem_wdata,
    input  logic              i_dmem_ack,
    input  logic [DATA_W-1:0] i_dmem_rdata,
    output logic [DATA_W-1:0] o_alu_x,
    output logic [DATA_W-1:0] o_alu_y,
    output logic [CTRL_W-1:0] o_alu_ctrl,
    input  logic [DATA_W-1:0] i_alu_out,
    input  logic              i_alu_zr,
    input  logic              i_alu_ng,
    output logic [ADDR_W-1:0] o_pc,
    output logic [DATA_W-1:0] o_areg,
    output logic [DATA_W-1:0] o_dreg
);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] areg;
    logic [DATA_W-1:0] dreg;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] mlat;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;

    logic              exec;
    logic              taken;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] pc_inc;

    assign exec   = (state == EXEC);
    assign a_addr = areg[ADDR_W-1:0];
    assign pc_inc = pc + ADDR_W'(1);

    jump_cond u_jump_cond (
        .jjj   (ir[JMP_HI:JMP_LO]),
        .zr    (i_alu_zr),
        .ng    (i_alu_ng),
        .taken (taken)
    );

    // Gated by reset so a sampled reset drops the fetch at once.
    assign o_imem_req  = i_rst_n & (state == FETCH);
    assign o_imem_addr = pc;

    assign o_dmem_req   = dm_req;
    assign o_dmem_we    = dm_we;
    assign o_dmem_addr  = dm_addr;
    assign o_dmem_wdata = dm_wdata;

    assign o_alu_ctrl = exec ? ir[CTRL_HI:CTRL_LO] : '0;
    assign o_alu_x    = exec ? dreg : '0;
    assign o_alu_y    = !exec     ? '0
                      : ir[ABIT] ? mlat
                      :            areg;

    assign o_pc   = pc;
    assign o_areg = areg;
    assign o_dreg = dreg;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= FETCH;
            pc       <= '0;
            areg     <= '0;
            dreg     <= '0;
            ir       <= '0;
            mlat     <= '0;
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_addr  <= '0;
            dm_wdata <= '0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (i_imem_ack) begin
                        ir    <= i_instr;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    if (!ir[TYPE]) begin
                        areg  <= ir;
                        pc    <= pc_inc;
                        state <= FETCH;
                    end else if (ir[ABIT]) begin
                        dm_req  <= 1'b1;
                        dm_we   <= 1'b0;
                        dm_addr <= a_addr;
                        state   <= MREAD;
                    end else begin
                        state <= EXEC;
                    end
                end
                MREAD: begin
                    if (i_dmem_ack) begin
                        mlat   <= i_dmem_rdata;
                        dm_req <= 1'b0;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    // Write address and jump target both use A before d1.
                    dm_addr  <= a_addr;
                    dm_wdata <= i_alu_out;
                    if (ir[DEST_D1]) areg <= i_alu_out;
                    if (ir[DEST_D2]) dreg <= i_alu_out;
                    pc <= taken ? a_addr : pc_inc;
                    if (ir[DEST_D3]) begin
                        dm_req <= 1'b1;
                        dm_we  <= 1'b1;
                        state  <= MWRITE;
                    end else begin
                        state <= FETCH;
                    end
                end
                MWRITE: begin
                    if (i_dmem_ack) begin
                        dm_req <= 1'b0;
                        dm_we  <= 1'b0;
                        state  <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Bench for hack_cpu_ctrl: external Hack ALU, memory responders and an
// instruction-level reference model checked on every meaningful cycle.
module tb_hack_cpu_ctrl;

    localparam int DW = 16;
    localparam int AW = 15;
    localparam int MSZ = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hack_cpu_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    logic [DW-1:0] alu_x, alu_y, alu_out;
    logic [5:0]    alu_ctrl;
    logic          alu_zr, alu_ng;
    logic [AW-1:0] pc;
    logic [DW-1:0] areg, dreg;

    hack_cpu_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .o_imem_req   (bus.imem_req),
        .o_imem_addr  (bus.imem_addr),
        .i_imem_ack   (bus.imem_ack),
        .i_instr      (bus.instr),
        .o_dmem_req   (bus.dmem_req),
        .o_dmem_we    (bus.dmem_we),
        .o_dmem_addr  (bus.dmem_addr),
        .o_dmem_wdata (bus.dmem_wdata),
        .i_dmem_ack   (bus.dmem_ack),
        .i_dmem_rdata (bus.dmem_rdata),
        .o_alu_x      (alu_x),
        .o_alu_y      (alu_y),
        .o_alu_ctrl   (alu_ctrl),
        .i_alu_out    (alu_out),
        .i_alu_zr     (alu_zr),
        .i_alu_ng     (alu_ng),
        .o_pc         (pc),
        .o_areg       (areg),
        .o_dreg       (dreg)
    );

    function automatic logic [DW-1:0] hack_alu(input logic [DW-1:0] x,
                                               input logic [DW-1:0] y,
                                               input logic [5:0] c);
        logic [DW-1:0] xx, yy, o;
        xx = c[5] ? '0 : x;
        if (c[4]) xx = ~xx;
        yy = c[3] ? '0 : y;
        if (c[2]) yy = ~yy;
        o = c[1] ? xx + yy : xx & yy;
        if (c[0]) o = ~o;
        return o;
    endfunction

    always_comb begin
        alu_out = hack_alu(alu_x, alu_y, alu_ctrl);
        alu_zr  = (alu_out == '0);
        alu_ng  = alu_out[DW-1];
    end

    int total = 0;
    int bad = 0;

    logic [AW-1:0] m_pc;
    logic [DW-1:0] m_a, m_d;
    logic [DW-1:0] mdl_m [MSZ];
    logic [DW-1:0] resp_m [MSZ];
    logic          exp_rd, exp_wr;
    logic [AW-1:0] exp_raddr, exp_waddr;
    logic [DW-1:0] exp_wdata;
    logic          chk_en = 1'b0;
    logic          spur = 1'b0;

    logic [5:0]    seen_ctrl = '0;
    logic [DW-1:0] seen_y = '0;
    always @(negedge clk)
        if (alu_ctrl != 6'd0) begin
            seen_ctrl <= alu_ctrl;
            seen_y    <= alu_y;
        end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc   = '0;
        m_a    = '0;
        m_d    = '0;
        exp_rd = 1'b0;
        exp_wr = 1'b0;
    endtask

    task automatic model_step(input logic [DW-1:0] ins);
        logic [DW-1:0] y, o, old_a;
        logic tk;
        exp_rd = 1'b0;
        exp_wr = 1'b0;
        if (!ins[15]) begin
            m_a  = ins;
            m_pc = m_pc + 15'd1;
        end else begin
            old_a = m_a;
            y = ins[12] ? mdl_m[old_a[AW-1:0]] : old_a;
            o = hack_alu(m_d, y, ins[11:6]);
            tk = (ins[2] && o[DW-1]) || (ins[1] && o == 16'd0)
              || (ins[0] && !o[DW-1] && o != 16'd0);
            exp_rd    = ins[12];
            exp_raddr = old_a[AW-1:0];
            exp_wr    = ins[3];
            exp_waddr = old_a[AW-1:0];
            exp_wdata = o;
            if (ins[3]) mdl_m[old_a[AW-1:0]] = o;
            if (ins[5]) m_a = o;
            if (ins[4]) m_d = o;
            m_pc = tk ? old_a[AW-1:0] : m_pc + 15'd1;
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_en && rst_n) begin
            if (bus.imem_req) begin
                chk("pc", pc, m_pc);
                chk("areg", areg, m_a);
                chk("dreg", dreg, m_d);
                chk("imem_addr", bus.imem_addr, m_pc);
                chk("req_excl", bus.dmem_req, 0);
            end
            if (bus.dmem_req && bus.dmem_we) begin
                chk("wr_expected", exp_wr, 1);
                chk("wr_addr", bus.dmem_addr, exp_waddr);
                chk("wr_data", bus.dmem_wdata, exp_wdata);
            end
            if (bus.dmem_req && !bus.dmem_we) begin
                chk("rd_expected", exp_rd, 1);
                chk("rd_addr", bus.dmem_addr, exp_raddr);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        chk_en = 1'b0;
        rst_n  = 1'b0;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        rst_n  = 1'b1;
        chk_en = 1'b1;
    endtask

    task automatic exec_instr(input logic [DW-1:0] ins, input int iwait,
                              input int dwait);
        int n;
        int lat;
        n = 0;
        while (!bus.imem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.imem_req) begin
            chk("fetch_timeout", 0, 1);
            return;
        end
        repeat (iwait) @(negedge clk);
        bus.instr    = ins;
        bus.imem_ack = 1'b1;
        @(posedge clk);
        model_step(ins);
        @(negedge clk);
        bus.imem_ack = 1'b0;
        bus.instr    = 16'hDEAD;
        n = 0;
        while (!bus.imem_req && n < 50) begin
            if (bus.dmem_req) begin
                repeat (dwait) begin
                    @(negedge clk);
                    n++;
                end
                if (bus.dmem_we) resp_m[bus.dmem_addr] = bus.dmem_wdata;
                else bus.dmem_rdata = resp_m[bus.dmem_addr];
                bus.dmem_ack = 1'b1;
                @(negedge clk);
                n++;
                bus.dmem_ack   = 1'b0;
                bus.dmem_rdata = 16'hBEEF;
            end else begin
                bus.dmem_ack = spur;
                bus.imem_ack = spur;
                @(negedge clk);
                n++;
                bus.dmem_ack = 1'b0;
                bus.imem_ack = 1'b0;
            end
        end
        lat = 2;
        if (ins[15]) lat = 3 + (int'(ins[12]) + int'(ins[3])) * (1 + dwait);
        chk("latency", n + 1, lat);
    endtask

    task automatic preload(input int addr, input logic [DW-1:0] v);
        mdl_m[addr]  = v;
        resp_m[addr] = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t limit 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < MSZ; i++) begin
            mdl_m[i]  = '0;
            resp_m[i] = '0;
        end
        bus.imem_ack   = 1'b0;
        bus.dmem_ack   = 1'b0;
        bus.instr      = '0;
        bus.dmem_rdata = '0;
        repeat (3) @(negedge clk);

        chk("rst_pc", pc, 0);
        chk("rst_a", areg, 0);
        chk("rst_d", dreg, 0);
        chk("rst_ireq", bus.imem_req, 0);
        chk("rst_dreq", bus.dmem_req, 0);
        chk("rst_we", bus.dmem_we, 0);
        chk("rst_daddr", bus.dmem_addr, 0);
        chk("rst_wdata", bus.dmem_wdata, 0);
        chk("rst_ctrl", alu_ctrl, 0);
        model_reset();
        rst_n  = 1'b1;
        chk_en = 1'b1;

        exec_instr(16'h0015, 0, 0);
        chk("t1_a", areg, 16'd21);
        chk("t1_pc", pc, 1);

        do_reset();
        exec_instr(16'h0005, 2, 0);
        exec_instr(16'hEC10, 0, 0);
        chk("t2_ctrl", seen_ctrl, 6'b110000);
        chk("t2_y", seen_y, 16'd5);
        chk("t2_d", dreg, 16'd5);
        chk("t2_pc", pc, 2);

        do_reset();
        preload(100, 16'h1234);
        spur = 1'b1;
        exec_instr(16'h0064, 0, 0);
        exec_instr(16'hFC10, 1, 3);
        spur = 1'b0;
        chk("t3_y", seen_y, 16'h1234);
        chk("t3_d", dreg, 16'h1234);
        chk("t3_pc", pc, 2);

        do_reset();
        exec_instr(16'h0007, 0, 0);
        exec_instr(16'hEEA8, 0, 2);
        chk("t4_a", areg, 16'hFFFF);
        chk("t4_mem", resp_m[7], 16'hFFFF);
        chk("t4_pc", pc, 2);

        do_reset();
        exec_instr(16'hEA90, 0, 0);
        exec_instr(16'h0009, 0, 0);
        exec_instr(16'hE302, 0, 0);
        chk("jeq_taken", pc, 9);
        exec_instr(16'h7FFF, 0, 0);
        exec_instr(16'hEC10, 0, 0);
        exec_instr(16'hE350, 0, 0);
        chk("d_8000", dreg, 16'h8000);
        exec_instr(16'h0009, 0, 0);
        exec_instr(16'hE304, 0, 0);
        chk("jlt_taken", pc, 9);
        exec_instr(16'hE302, 0, 0);
        chk("jeq_not", pc, 10);
        exec_instr(16'hEFD0, 0, 0);
        exec_instr(16'h0009, 0, 0);
        exec_instr(16'hE301, 0, 0);
        chk("jgt_taken", pc, 9);
        exec_instr(16'hE304, 0, 0);
        chk("jlt_not", pc, 10);
        exec_instr(16'h0009, 0, 0);
        exec_instr(16'hEA87, 0, 0);
        chk("jmp_taken", pc, 9);

        do_reset();
        exec_instr(16'h0007, 0, 0);
        bus.instr    = 16'hEEA8;
        bus.imem_ack = 1'b1;
        @(posedge clk);
        model_step(16'hEEA8);
        @(negedge clk);
        bus.imem_ack = 1'b0;
        n = 0;
        while (!(bus.dmem_req && bus.dmem_we) && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("t6_in_write", bus.dmem_req && bus.dmem_we, 1);
        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        rst_n  = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_dreq", bus.dmem_req, 0);
        chk("t6_ireq", bus.imem_req, 0);
        chk("t6_pc", pc, 0);
        chk("t6_a", areg, 0);
        chk("t6_d", dreg, 0);
        @(negedge clk);
        bus.dmem_ack = 1'b1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_late_dreq", bus.dmem_req, 0);
        chk("t6_fetch", bus.imem_req, 1);
        chk("t6_late_pc", pc, 0);
        @(negedge clk);
        bus.dmem_ack = 1'b0;
        model_reset();
        chk_en = 1'b1;
        exec_instr(16'h0015, 0, 0);
        chk("t6_after_a", areg, 16'd21);

        do_reset();
        exec_instr(16'h7FFF, 0, 0);
        exec_instr(16'hEA87, 0, 0);
        chk("t7_pc_max", pc, 15'h7FFF);
        exec_instr(16'h0015, 0, 0);
        chk("t7_wrap", pc, 0);
        chk("t7_a", areg, 16'd21);

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
